// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the grid SRAM arbiter: one request/response channel
// for the wave-expansion engine (a_*) and one for the backtrace engine (b_*).
interface sram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_done;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_done;

    // engines drive requests and completion pulses
    modport master (
        output a_req, a_we, a_addr, a_wdata, a_done,
        output b_req, b_we, b_addr, b_wdata, b_done,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    // arbiter answers with grants and read data
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_done,
        input  b_req, b_we, b_addr, b_wdata, b_done,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter/sequencer for the maze router's single-port grid SRAM.
// Round-robin between the wave-expansion (A) and backtrace (B) engines, raises
// the SRAM dump trigger once both engines report completion.
// Build option: SRAM_CLEAR_EN adds a post-reset sweep writing zero to every
// word (RAM_DEPTH words); without it reset lands directly in RUN and the
// RAM_DEPTH parameter does not exist.
//
// state  | meaning
// CLEAR  | post-reset zero sweep of the grid, no grants
// RUN    | normal round-robin arbitration
// DRAIN  | both engines done, last granted read still returning
// FINISH | dump trigger raised, held until rst
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
`ifdef SRAM_CLEAR_EN
    ,parameter int RAM_DEPTH = 1 << ADDR_WIDTH
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_arbiter_if.slave    req_bus,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic [DATA_WIDTH-1:0] sram_data_out,
    output logic                  sram_D,
    output logic                  busy
);
    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

`ifdef SRAM_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    localparam int     CNT_W       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    state_t state, state_next;
    logic   a_flag, b_flag;
    logic   last_b;
    logic   a_rvalid_q, b_rvalid_q;
    logic   run_active, a_elig, b_elig, a_gnt_i, b_gnt_i;
    logic   both_done_next, read_now;

    // rst gates grants so a request in a reset cycle never completes
    assign run_active = (state == RUN) && !rst;
    assign a_elig     = req_bus.a_req && !a_flag;
    assign b_elig     = req_bus.b_req && !b_flag;
    assign a_gnt_i    = run_active && a_elig && (!b_elig || last_b);
    assign b_gnt_i    = run_active && b_elig && (!a_elig || !last_b);

    // done flags take effect for the grant decision only from the next cycle,
    // but the exit decision looks at this cycle's pulses
    assign both_done_next = (a_flag || req_bus.a_done) && (b_flag || req_bus.b_done);
    assign read_now       = (a_gnt_i && !req_bus.a_we) || (b_gnt_i && !req_bus.b_we);

    assign req_bus.a_gnt    = a_gnt_i;
    assign req_bus.b_gnt    = b_gnt_i;
    assign req_bus.a_rvalid = a_rvalid_q;
    assign req_bus.b_rvalid = b_rvalid_q;
    assign req_bus.a_rdata  = a_rvalid_q ? sram_data_out : '0;
    assign req_bus.b_rdata  = b_rvalid_q ? sram_data_out : '0;

    assign sram_D = (state == FINISH) && !rst;
    assign busy   = rst ? (RESET_STATE == CLEAR) : (state == CLEAR || state == FINISH);

`ifdef SRAM_CLEAR_EN
    logic [CNT_W-1:0] clr_cnt;
    logic             clr_last;

    assign clr_last = (clr_cnt == CNT_W'(RAM_DEPTH - 1));

    // sweep address counter, holds at the last word once the sweep is over
    always_ff @(posedge clk) begin
        if (rst)
            clr_cnt <= '0;
        else if (state == CLEAR && !clr_last)
            clr_cnt <= clr_cnt + CNT_W'(1);
    end
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= RESET_STATE;
        else
            state <= state_next;
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
`ifdef SRAM_CLEAR_EN
            CLEAR:   if (clr_last) state_next = RUN;
`endif
            RUN:     if (both_done_next) state_next = read_now ? DRAIN : FINISH;
            DRAIN:   state_next = FINISH;
            FINISH:  state_next = FINISH;
            default: state_next = RESET_STATE;
        endcase
    end

    // sticky done flags, round-robin pointer and read-return strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            a_flag     <= 1'b0;
            b_flag     <= 1'b0;
            last_b     <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            if (req_bus.a_done) a_flag <= 1'b1;
            if (req_bus.b_done) b_flag <= 1'b1;
            if (a_gnt_i)
                last_b <= 1'b0;
            else if (b_gnt_i)
                last_b <= 1'b1;
            a_rvalid_q <= a_gnt_i && !req_bus.a_we;
            b_rvalid_q <= b_gnt_i && !req_bus.b_we;
        end
    end

    // SRAM port drive: sweep writes in CLEAR, granted port in RUN, idle otherwise
    always_comb begin
        sram_cs      = 1'b0;
        sram_we      = 1'b0;
        sram_address = '0;
        sram_data_in = '0;
        case (state)
`ifdef SRAM_CLEAR_EN
            CLEAR: begin
                if (!rst) begin
                    sram_cs      = 1'b1;
                    sram_we      = 1'b1;
                    sram_address = ADDR_WIDTH'(clr_cnt);
                end
            end
`endif
            RUN: begin
                sram_cs = a_gnt_i || b_gnt_i;
                if (a_gnt_i) begin
                    sram_we      = req_bus.a_we;
                    sram_address = req_bus.a_addr;
                    sram_data_in = req_bus.a_wdata;
                end else if (b_gnt_i) begin
                    sram_we      = req_bus.b_we;
                    sram_address = req_bus.b_addr;
                    sram_data_in = req_bus.b_wdata;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural
// single-port SRAM (registered read) attached to the SRAM-side ports.
module tb_sram_port_arbiter;
    localparam int DW        = 8;
    localparam int AW        = 8;
    localparam int RAM_DEPTH = 256;
`ifdef SRAM_CLEAR_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          sram_cs, sram_we, sram_D, busy;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_data_in, sram_data_out;
    logic [DW-1:0] mem [0:RAM_DEPTH-1];

    int checks = 0;
    int errors = 0;

    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_bus       (bus),
        .sram_cs       (sram_cs),
        .sram_we       (sram_we),
        .sram_address  (sram_address),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out),
        .sram_D        (sram_D),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_address] <= sram_data_in;
            else         sram_data_out     <= mem[sram_address];
        end
    end

    task automatic clear_inputs();
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_done = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_done = 0;
    endtask

    task automatic idle();
        @(negedge clk);
        clear_inputs();
    endtask

    // drops rst and returns at the start of the first cycle in which a grant is possible
    task automatic release_reset();
        @(negedge clk);
        rst = 0;
        clear_inputs();
`ifdef SRAM_CLEAR_EN
        repeat (RAM_DEPTH) @(negedge clk);
`endif
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.a_req = 1; bus.b_req = 1;
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.a_gnt, bus.b_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_gnt: got %b expected 00", {bus.a_gnt, bus.b_gnt});
        end
        checks++;
        if ({bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata} !== 18'h0) begin
            errors++; $display("FAIL reset_read: got %h expected 0", {bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata});
        end
        checks++;
        if ({sram_cs, sram_we, sram_address, sram_data_in} !== 18'h0) begin
            errors++; $display("FAIL reset_sram: got %h expected 0", {sram_cs, sram_we, sram_address, sram_data_in});
        end
        checks++;
        if (sram_D !== 1'b0) begin
            errors++; $display("FAIL reset_dump: got %b expected 0", sram_D);
        end
        checks++;
        if (busy !== EXP_BUSY) begin
            errors++; $display("FAIL reset_busy: got %b expected %b", busy, EXP_BUSY);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        rst = 0;
        clear_inputs();
        bus.a_req = 1; bus.a_we = 1;
`ifdef SRAM_CLEAR_EN
        for (int i = 0; i < RAM_DEPTH; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if ({sram_cs, sram_we, sram_address, sram_data_in, bus.a_gnt, bus.b_gnt, busy} !== {2'b11, 8'(i), 8'h00, 3'b001}) begin
                errors++;
                $display("FAIL clear_sweep[%0d]: got cs=%b we=%b addr=%h data=%h gnt=%b%b busy=%b expected cs=1 we=1 addr=%h data=00 gnt=00 busy=1",
                         i, sram_cs, sram_we, sram_address, sram_data_in, bus.a_gnt, bus.b_gnt, busy, 8'(i));
            end
        end
        @(negedge clk);
`endif
        #1;
        checks++;
        if ({bus.a_gnt, busy, sram_cs, sram_address} !== {3'b101, 8'h00}) begin
            errors++; $display("FAIL first_grant: got gnt=%b busy=%b cs=%b addr=%h expected gnt=1 busy=0 cs=1 addr=00",
                               bus.a_gnt, busy, sram_cs, sram_address);
        end
        idle();
    endtask

    task automatic test_single_port();
        @(negedge clk);
        clear_inputs();
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 8'h10; bus.a_wdata = 8'h5A;
        #1;
        checks++;
        if ({bus.a_gnt, bus.b_gnt, sram_cs, sram_we, sram_address, sram_data_in} !== {4'b1011, 8'h10, 8'h5A}) begin
            errors++; $display("FAIL a_write: got gnt=%b%b cs=%b we=%b addr=%h data=%h expected gnt=10 cs=1 we=1 addr=10 data=5a",
                               bus.a_gnt, bus.b_gnt, sram_cs, sram_we, sram_address, sram_data_in);
        end
        @(negedge clk);
        bus.a_we = 0; bus.a_wdata = '0;
        #1;
        checks++;
        if ({bus.a_gnt, sram_cs, sram_we, sram_address, bus.a_rvalid} !== {3'b110, 8'h10, 1'b0}) begin
            errors++; $display("FAIL a_read_grant: got gnt=%b cs=%b we=%b addr=%h rvalid=%b expected gnt=1 cs=1 we=0 addr=10 rvalid=0",
                               bus.a_gnt, sram_cs, sram_we, sram_address, bus.a_rvalid);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({bus.a_rvalid, bus.a_rdata, bus.b_rvalid, sram_cs} !== {1'b1, 8'h5A, 2'b00}) begin
            errors++; $display("FAIL a_read_data: got rvalid=%b rdata=%h b_rvalid=%b cs=%b expected rvalid=1 rdata=5a b_rvalid=0 cs=0",
                               bus.a_rvalid, bus.a_rdata, bus.b_rvalid, sram_cs);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.a_rvalid, bus.a_rdata} !== 9'h0) begin
            errors++; $display("FAIL a_rdata_gate: got rvalid=%b rdata=%h expected rvalid=0 rdata=00", bus.a_rvalid, bus.a_rdata);
        end
        idle();
    endtask

    task automatic test_port_b();
        @(negedge clk);
        clear_inputs();
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 8'h20; bus.b_wdata = 8'h33;
        #1;
        checks++;
        if ({bus.a_gnt, bus.b_gnt, sram_we, sram_address, sram_data_in} !== {3'b011, 8'h20, 8'h33}) begin
            errors++; $display("FAIL b_write: got gnt=%b%b we=%b addr=%h data=%h expected gnt=01 we=1 addr=20 data=33",
                               bus.a_gnt, bus.b_gnt, sram_we, sram_address, sram_data_in);
        end
        @(negedge clk);
        bus.b_we = 0;
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({bus.b_rvalid, bus.b_rdata, bus.a_rvalid, bus.a_rdata} !== {1'b1, 8'h33, 9'h0}) begin
            errors++; $display("FAIL b_read_data: got b_rvalid=%b b_rdata=%h a_rvalid=%b a_rdata=%h expected 1 33 0 00",
                               bus.b_rvalid, bus.b_rdata, bus.a_rvalid, bus.a_rdata);
        end
        idle();
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) begin
            logic          exp_a;
            logic [AW-1:0] exp_addr;
            exp_a    = (i % 2 == 0);
            exp_addr = exp_a ? 8'h01 : 8'h02;
            @(negedge clk);
            clear_inputs();
            bus.a_req = 1; bus.a_we = 1; bus.a_addr = 8'h01; bus.a_wdata = 8'h11;
            bus.b_req = 1; bus.b_we = 1; bus.b_addr = 8'h02; bus.b_wdata = 8'h22;
            #1;
            checks++;
            if ({bus.a_gnt, bus.b_gnt, sram_address} !== {exp_a, !exp_a, exp_addr}) begin
                errors++; $display("FAIL contention[%0d]: got gnt=%b%b addr=%h expected gnt=%b%b addr=%h",
                                   i, bus.a_gnt, bus.b_gnt, sram_address, exp_a, !exp_a, exp_addr);
            end
        end
        idle();
    endtask

    task automatic test_done_drain();
        @(negedge clk);
        clear_inputs();
        bus.b_done = 1;
        #1;
        checks++;
        if ({sram_D, busy} !== 2'b00) begin
            errors++; $display("FAIL drain_b_done: got dump=%b busy=%b expected 00", sram_D, busy);
        end
        @(negedge clk);
        clear_inputs();
        bus.a_req = 1; bus.a_addr = 8'h10; bus.a_done = 1;
        bus.b_req = 1; bus.b_addr = 8'h20;
        #1;
        checks++;
        if ({bus.a_gnt, bus.b_gnt, sram_address} !== {2'b10, 8'h10}) begin
            errors++; $display("FAIL drain_last_read: got gnt=%b%b addr=%h expected gnt=10 addr=10",
                               bus.a_gnt, bus.b_gnt, sram_address);
        end
        @(negedge clk);
        clear_inputs();
        bus.b_req = 1; bus.b_addr = 8'h20;
        #1;
        checks++;
        if ({bus.a_rvalid, bus.a_rdata, sram_D, busy, bus.b_gnt} !== {1'b1, 8'h5A, 3'b000}) begin
            errors++; $display("FAIL drain_cycle: got rvalid=%b rdata=%h dump=%b busy=%b b_gnt=%b expected 1 5a 0 0 0",
                               bus.a_rvalid, bus.a_rdata, sram_D, busy, bus.b_gnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({sram_D, busy, bus.b_gnt, bus.a_rvalid} !== 4'b1100) begin
            errors++; $display("FAIL drain_finish: got dump=%b busy=%b b_gnt=%b rvalid=%b expected 1 1 0 0",
                               sram_D, busy, bus.b_gnt, bus.a_rvalid);
        end
        @(negedge clk);
        bus.a_req = 1;
        #1;
        checks++;
        if ({bus.a_gnt, bus.b_gnt, sram_cs, sram_D} !== 4'b0001) begin
            errors++; $display("FAIL finish_hold: got gnt=%b%b cs=%b dump=%b expected gnt=00 cs=0 dump=1",
                               bus.a_gnt, bus.b_gnt, sram_cs, sram_D);
        end
        idle();
    endtask

    task automatic test_reset_finish();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        #1;
        checks++;
        if ({sram_D, busy} !== {1'b0, EXP_BUSY}) begin
            errors++; $display("FAIL finish_reset: got dump=%b busy=%b expected dump=0 busy=%b", sram_D, busy, EXP_BUSY);
        end
        release_reset();
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 8'h30; bus.a_wdata = 8'h44;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 8'h31; bus.b_wdata = 8'h55;
        #1;
        checks++;
        if ({bus.a_gnt, bus.b_gnt, busy, sram_D} !== 4'b1000) begin
            errors++; $display("FAIL post_reset_a: got gnt=%b%b busy=%b dump=%b expected gnt=10 busy=0 dump=0",
                               bus.a_gnt, bus.b_gnt, busy, sram_D);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.a_gnt, bus.b_gnt, sram_address} !== {2'b01, 8'h31}) begin
            errors++; $display("FAIL post_reset_b: got gnt=%b%b addr=%h expected gnt=01 addr=31",
                               bus.a_gnt, bus.b_gnt, sram_address);
        end
        idle();
    endtask

    task automatic test_done_no_drain();
        @(negedge clk);
        clear_inputs();
        bus.a_done = 1;
        #1;
        checks++;
        if (sram_D !== 1'b0) begin
            errors++; $display("FAIL nodrain_a_done: got dump=%b expected 0", sram_D);
        end
        @(negedge clk);
        clear_inputs();
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 8'h40; bus.a_wdata = 8'h66;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 8'h41; bus.b_wdata = 8'h77; bus.b_done = 1;
        #1;
        checks++;
        if ({bus.a_gnt, bus.b_gnt, sram_address, sram_D} !== {2'b01, 8'h41, 1'b0}) begin
            errors++; $display("FAIL nodrain_last_write: got gnt=%b%b addr=%h dump=%b expected gnt=01 addr=41 dump=0",
                               bus.a_gnt, bus.b_gnt, sram_address, sram_D);
        end
        @(negedge clk);
        clear_inputs();
        bus.b_req = 1;
        #1;
        checks++;
        if ({sram_D, busy, bus.b_gnt} !== 3'b110) begin
            errors++; $display("FAIL nodrain_finish: got dump=%b busy=%b b_gnt=%b expected 1 1 0", sram_D, busy, bus.b_gnt);
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        rst = 1;
        release_reset();
        bus.a_req = 1; bus.a_addr = 8'h10;
        rst = 1;
        #1;
        checks++;
        if ({bus.a_gnt, sram_cs} !== 2'b00) begin
            errors++; $display("FAIL rst_read_gnt: got gnt=%b cs=%b expected 00", bus.a_gnt, sram_cs);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({bus.a_rvalid, bus.a_rdata} !== 9'h0) begin
            errors++; $display("FAIL rst_read_rvalid: got rvalid=%b rdata=%h expected 0 00", bus.a_rvalid, bus.a_rdata);
        end
    endtask

`ifdef SRAM_CLEAR_EN
    task automatic test_reset_mid_clear();
        @(negedge clk);
        rst = 0;
        clear_inputs();
        repeat (100) @(negedge clk);
        #1;
        checks++;
        if ({sram_cs, sram_address} !== {1'b1, 8'd100}) begin
            errors++; $display("FAIL midclear_addr: got cs=%b addr=%0d expected cs=1 addr=100", sram_cs, sram_address);
        end
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({sram_cs, sram_we, busy} !== 3'b001) begin
            errors++; $display("FAIL midclear_rst: got cs=%b we=%b busy=%b expected 0 0 1", sram_cs, sram_we, busy);
        end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if ({sram_cs, sram_address} !== {1'b1, 8'd0}) begin
            errors++; $display("FAIL midclear_restart: got cs=%b addr=%0d expected cs=1 addr=0", sram_cs, sram_address);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sram_address !== 8'd1) begin
            errors++; $display("FAIL midclear_step: got addr=%0d expected 1", sram_address);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
        sram_data_out = '0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_clear();
        test_single_port();
        test_port_b();
        test_contention();
        test_done_drain();
        test_reset_finish();
        test_done_no_drain();
        test_reset_mid_read();
`ifdef SRAM_CLEAR_EN
        test_reset_mid_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
